// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
//
// Owns the fetch PC and issues word-aligned requests to instruction memory
// (valid/ready). In-order responses are written into a small registered FIFO,
// which presents {instruction, PC} pairs to decode (valid/ready). A redirect
// empties the FIFO and restarts fetch at a new target. Responses still owed
// for requests made before the redirect are counted and discarded.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   imem_req_valid_o/ready_i     request handshake
//   imem_req_addr_o              word-aligned fetch address
//   imem_rsp_valid_i/data_i      in-order response, never back-pressured
//   instr_valid_o/ready_i        instruction handshake to decode
//   instr_data_o, instr_pc_o     head instruction and its PC (NOP/0 when empty)
//   redirect_i, redirect_pc_i    flush and restart at redirect_pc_i[31:2]

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_FETCH = 1'b1;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [0:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W:0]   credit_sum_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_nonempty_s;
    logic [CNT_W-1:0] req_inc_s;
    logic [CNT_W-1:0] rsp_dec_s;
    logic [31:0]      redirect_base_s;

    // Handshake qualifiers shared by next-state logic and outputs.
    always_comb begin
        fifo_nonempty_s = (count_q != CNT_W'(0));
        // Buffered entries plus requests in flight may never exceed the depth,
        // so a kept response always has a free slot.
        credit_sum_s    = {1'b0, count_q} + {1'b0, outstanding_q};
        req_valid_s     = (state_q == ST_FETCH) && !redirect_i &&
                          (credit_sum_s < {1'b0, DEPTH_C});
        req_fire_s      = req_valid_s && imem_req_ready_i;
        push_s          = imem_rsp_valid_i && (discard_q == CNT_W'(0)) && !redirect_i;
        pop_s           = fifo_nonempty_s && instr_ready_i && !redirect_i;
        req_inc_s       = CNT_W'(req_fire_s);
        rsp_dec_s       = CNT_W'(imem_rsp_valid_i);
        redirect_base_s = {redirect_pc_i[31:2], 2'b00};
    end

    // Next-state computation; redirect overrides every other update.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase

        if (redirect_i) begin
            fetch_pc_d    = redirect_base_s;
            rsp_pc_d      = redirect_base_s;
            rd_ptr_d      = PTR_W'(0);
            wr_ptr_d      = PTR_W'(0);
            count_d       = CNT_W'(0);
            // No request is issued this cycle, so everything still owed after
            // this cycle belongs to the old stream.
            outstanding_d = outstanding_q - rsp_dec_s;
            discard_d     = outstanding_q - rsp_dec_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            outstanding_d = outstanding_q + req_inc_s - rsp_dec_s;
            if (imem_rsp_valid_i && (discard_q != CNT_W'(0))) begin
                discard_d = discard_q - CNT_W'(1);
            end else begin
                discard_d = discard_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end else begin
                wr_ptr_d = wr_ptr_q;
                rsp_pc_d = rsp_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Control and PC state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            rd_ptr_q      <= PTR_W'(0);
            wr_ptr_q      <= PTR_W'(0);
            count_q       <= CNT_W'(0);
            outstanding_q <= CNT_W'(0);
            discard_q     <= CNT_W'(0);
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // FIFO storage; written only by kept responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= NOP_INSN;
                fifo_pc_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= imem_rsp_data_i;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end else begin
            fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
            fifo_pc_q[wr_ptr_q]   <= fifo_pc_q[wr_ptr_q];
        end
    end

    // Output drive; all values come straight from registers except the
    // request valid, which must drop in the redirect cycle.
    always_comb begin
        imem_req_valid_o = req_valid_s;
        imem_req_addr_o  = fetch_pc_q;
        instr_valid_o    = fifo_nonempty_s;
        if (fifo_nonempty_s) begin
            instr_data_o = fifo_data_q[rd_ptr_q];
            instr_pc_o   = fifo_pc_q[rd_ptr_q];
        end else begin
            instr_data_o = NOP_INSN;
            instr_pc_o   = 32'h0000_0000;
        end
    end

    fetch_unit_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rsp_valid_i   (imem_rsp_valid_i),
        .push_i        (push_s),
        .pop_i         (pop_s),
        .count_i       (count_q),
        .outstanding_i (outstanding_q),
        .discard_i     (discard_q)
    );
endmodule

// fetch_unit_chk: protocol and bookkeeping invariants of fetch_unit.
// Ports: clock/reset plus the response, push/pop and counter state.
module fetch_unit_chk #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             rsp_valid_i,
    input logic             push_i,
    input logic             pop_i,
    input logic [CNT_W-1:0] count_i,
    input logic [CNT_W-1:0] outstanding_i,
    input logic [CNT_W-1:0] discard_i
);
    // Invariant checks, evaluated on every active edge outside reset.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(rsp_valid_i && (outstanding_i == CNT_W'(0))))
                else $error("response with nothing outstanding");
            assert (!(push_i && (count_i == CNT_W'(FIFO_DEPTH)) && !pop_i))
                else $error("kept response into full buffer");
            assert (outstanding_i <= CNT_W'(FIFO_DEPTH))
                else $error("outstanding above depth");
            assert (discard_i <= outstanding_i)
                else $error("discard above outstanding");
        end
    end
endmodule
